// File: rtl/i2c_target.sv
// ---------------------------------------------------------------------------
// i2c_target
//
// Purpose:
//   I2C target (slave) with a fixed 7-bit address.  Accepts write transfers
//   byte by byte (always ACKing) and serves read transfers from tx_data,
//   refetching tx_data for every byte the master ACKs.  SCL and SDA are
//   oversampled with the system clock, so SCL high and low phases must each
//   last at least 4 clk.
//
// Parameters:
//   TARGET_ADDR : 7-bit bus address this block answers to.
//
// Ports:
//   clk      in     system clock, all state on its rising edge
//   rst      in     asynchronous active-high reset
//   i2c_scl  in     bus clock, sampled only
//   i2c_sda  inout  open-drain bus data, driven 1'b0 or left 1'bz
//   tx_data  in     byte returned to the master on a read
//   rx_data  out    last byte received on a write
//   rx_valid out    one-clk pulse when rx_data updates
//   tx_req   out    one-clk pulse when tx_data has been captured
//   busy     out    high from an address match until STOP or abort
// ---------------------------------------------------------------------------
module i2c_target #(
   parameter logic [6:0] TARGET_ADDR = 7'b1010001
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i2c_scl,
   inout  wire        i2c_sda,
   input  logic [7:0] tx_data,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       tx_req,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ADDR      = 3'd1,
      ADDR_ACK  = 3'd2,
      RX_BYTE   = 3'd3,
      RX_ACK    = 3'd4,
      TX_BYTE   = 3'd5,
      TX_ACK    = 3'd6,
      WAIT_STOP = 3'd7
   } state_e;

   // [0],[1] form the synchronizer, [2] is the delayed copy for edge detection
   logic [2:0] scl_sync_q;
   logic [2:0] sda_sync_q;

   state_e     state_q;
   logic [3:0] bit_cnt_q;
   logic [6:0] shift_q;
   logic [7:0] tx_shift_q;
   logic       rw_q;
   logic       sda_oe_q;
   logic [7:0] rx_data_q;
   logic       rx_valid_q;
   logic       tx_req_q;
   logic       busy_q;

   logic       scl_rise;
   logic       scl_fall;
   logic       sda_in;
   logic       start_det;
   logic       stop_det;

   // Synchronize both bus lines and keep one extra delayed copy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_sync_q <= 3'b111;
         sda_sync_q <= 3'b111;
      end else begin
         scl_sync_q <= {scl_sync_q[1:0], i2c_scl};
         sda_sync_q <= {sda_sync_q[1:0], i2c_sda};
      end
   end

   assign sda_in   = sda_sync_q[1];
   assign scl_rise =  scl_sync_q[1] & ~scl_sync_q[2];
   assign scl_fall = ~scl_sync_q[1] &  scl_sync_q[2];

   // START/STOP require SCL stable high across the SDA transition, so an SDA
   // change that coincides with an SCL edge is never taken as a condition.
   assign start_det = ~sda_sync_q[1] &  sda_sync_q[2] & scl_sync_q[1] & scl_sync_q[2];
   assign stop_det  =  sda_sync_q[1] & ~sda_sync_q[2] & scl_sync_q[1] & scl_sync_q[2];

   // Protocol FSM with all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         bit_cnt_q  <= 4'd0;
         shift_q    <= 7'd0;
         tx_shift_q <= 8'h00;
         rw_q       <= 1'b0;
         sda_oe_q   <= 1'b0;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         tx_req_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         tx_req_q   <= 1'b0;

         if (start_det) begin
            // Repeated START restarts address reception from any state.
            state_q   <= ADDR;
            bit_cnt_q <= 4'd0;
            shift_q   <= 7'd0;
            sda_oe_q  <= 1'b0;
         end else if (stop_det) begin
            // Any partial byte is dropped silently.
            state_q   <= IDLE;
            bit_cnt_q <= 4'd0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  sda_oe_q  <= 1'b0;
                  bit_cnt_q <= 4'd0;
               end

               ADDR: begin
                  if (scl_rise) begin
                     shift_q <= {shift_q[5:0], sda_in};
                     if (bit_cnt_q == 4'd7) begin
                        // shift_q holds bits [7:1]; sda_in is the R/W bit
                        bit_cnt_q <= 4'd0;
                        if (shift_q == TARGET_ADDR) begin
                           state_q <= ADDR_ACK;
                           rw_q    <= sda_in;
                           busy_q  <= 1'b1;
                        end else begin
                           state_q <= WAIT_STOP;
                           busy_q  <= 1'b0;
                        end
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                     end
                  end
               end

               ADDR_ACK: begin
                  // First falling edge starts the ACK, second one ends it.
                  if (scl_fall) begin
                     if (!sda_oe_q) begin
                        sda_oe_q <= 1'b1;
                     end else begin
                        bit_cnt_q <= 4'd0;
                        if (rw_q) begin
                           // Read: the MSB goes out on the edge that ends the ACK.
                           tx_shift_q <= tx_data;
                           tx_req_q   <= 1'b1;
                           sda_oe_q   <= ~tx_data[7];
                           state_q    <= TX_BYTE;
                        end else begin
                           sda_oe_q <= 1'b0;
                           state_q  <= RX_BYTE;
                        end
                     end
                  end
               end

               RX_BYTE: begin
                  if (scl_rise) begin
                     shift_q <= {shift_q[5:0], sda_in};
                     if (bit_cnt_q == 4'd7) begin
                        rx_data_q  <= {shift_q, sda_in};
                        rx_valid_q <= 1'b1;
                        bit_cnt_q  <= 4'd0;
                        state_q    <= RX_ACK;
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                     end
                  end
               end

               RX_ACK: begin
                  if (scl_fall) begin
                     if (!sda_oe_q) begin
                        sda_oe_q <= 1'b1;
                     end else begin
                        sda_oe_q  <= 1'b0;
                        bit_cnt_q <= 4'd0;
                        state_q   <= RX_BYTE;
                     end
                  end
               end

               TX_BYTE: begin
                  // bit_cnt_q counts rising edges already seen for this byte.
                  if (scl_rise) begin
                     if (bit_cnt_q != 4'd8) begin
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                     end else begin
                        bit_cnt_q <= bit_cnt_q;
                     end
                  end else if (scl_fall) begin
                     if (bit_cnt_q == 4'd0) begin
                        // Byte fetched at the master ACK: present its MSB now.
                        sda_oe_q <= ~tx_shift_q[7];
                     end else if (bit_cnt_q == 4'd8) begin
                        sda_oe_q  <= 1'b0;
                        bit_cnt_q <= 4'd0;
                        state_q   <= TX_ACK;
                     end else begin
                        tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                        sda_oe_q   <= ~tx_shift_q[6];
                     end
                  end else begin
                     sda_oe_q <= sda_oe_q;
                  end
               end

               TX_ACK: begin
                  if (scl_rise) begin
                     bit_cnt_q <= 4'd0;
                     if (!sda_in) begin
                        tx_shift_q <= tx_data;
                        tx_req_q   <= 1'b1;
                        state_q    <= TX_BYTE;
                     end else begin
                        state_q <= WAIT_STOP;
                     end
                  end
               end

               WAIT_STOP: begin
                  sda_oe_q  <= 1'b0;
                  bit_cnt_q <= 4'd0;
               end

               default: begin
                  state_q   <= IDLE;
                  sda_oe_q  <= 1'b0;
                  bit_cnt_q <= 4'd0;
                  busy_q    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign i2c_sda  = sda_oe_q ? 1'b0 : 1'bz;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign tx_req   = tx_req_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// ---------------------------------------------------------------------------
// tb_i2c_target
//
// Bench for i2c_target.  A bus master is modelled with tasks driving SCL and
// an open-drain SDA (with pull-up).  Write transfers come from a table of
// records; read, repeated START and abort cases are hand-written sequences.
// Pulse counters on the negative clock edge count rx_valid / tx_req cycles
// and cycles in which SDA is low while the master is not pulling it.
// ---------------------------------------------------------------------------
module tb_i2c_target;

   logic       clk = 1'b0;
   logic       rst;
   logic       scl;
   logic       m_low;
   logic [7:0] tx_data;
   wire  [7:0] rx_data;
   wire        rx_valid;
   wire        tx_req;
   wire        busy;
   wire        sda_bus;

   assign sda_bus = m_low ? 1'b0 : 1'bz;
   pullup (sda_bus);

   i2c_target #(.TARGET_ADDR(7'b1010001)) dut (
      .clk      (clk),
      .rst      (rst),
      .i2c_scl  (scl),
      .i2c_sda  (sda_bus),
      .tx_data  (tx_data),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_req   (tx_req),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int rx_pulses = 0;
   int tx_pulses = 0;
   int dut_lows  = 0;

   // Count output pulses and target-driven SDA lows away from the active edge.
   always @(negedge clk) begin
      if (rx_valid) rx_pulses <= rx_pulses + 1;
      if (tx_req)   tx_pulses <= tx_pulses + 1;
      if (!m_low && sda_bus === 1'b0) dut_lows <= dut_lows + 1;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One SCL period: set SDA in the low phase, sample SDA mid high phase.
   task automatic clk_bit(input logic drive_low, output logic sampled);
      wait_clk(4);
      m_low = drive_low;
      wait_clk(4);
      scl = 1'b1;
      wait_clk(4);
      sampled = sda_bus;
      wait_clk(4);
      scl = 1'b0;
   endtask

   task automatic start_cond();
      if (scl == 1'b0) begin
         wait_clk(4);
         m_low = 1'b0;
         wait_clk(4);
         scl = 1'b1;
         wait_clk(8);
      end
      m_low = 1'b1;
      wait_clk(8);
      scl = 1'b0;
   endtask

   task automatic stop_cond();
      wait_clk(4);
      m_low = 1'b1;
      wait_clk(4);
      scl = 1'b1;
      wait_clk(8);
      m_low = 1'b0;
      wait_clk(8);
   endtask

   // Eight data bits plus the 9th clock; ack = SDA low on the 9th clock.
   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clk_bit(~b[i], s);
      clk_bit(1'b0, s);
      ack = ~s;
   endtask

   task automatic read8(output logic [7:0] b);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b0, s);
         b[i] = s;
      end
   endtask

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
      logic       exp_aack;
      logic       exp_dack;
      logic       exp_busy;
      int         exp_rx;
      logic [7:0] exp_rxd;
   } vec_t;

   vec_t vecs[7];

   initial begin
      logic       a;
      logic       s;
      logic [7:0] b;
      int         rx0;
      int         tx0;
      int         low0;

      vecs[0] = '{8'hA2, 8'hAA, 1'b1, 1'b1, 1'b1, 1, 8'hAA};
      vecs[1] = '{8'hA4, 8'h55, 1'b0, 1'b0, 1'b0, 0, 8'hAA};
      vecs[2] = '{8'hA2, 8'h00, 1'b1, 1'b1, 1'b1, 1, 8'h00};
      vecs[3] = '{8'hA2, 8'hFF, 1'b1, 1'b1, 1'b1, 1, 8'hFF};
      vecs[4] = '{8'hA0, 8'h22, 1'b0, 1'b0, 1'b0, 0, 8'hFF};
      vecs[5] = '{8'hE2, 8'h33, 1'b0, 1'b0, 1'b0, 0, 8'hFF};
      vecs[6] = '{8'hA2, 8'h5A, 1'b1, 1'b1, 1'b1, 1, 8'h5A};

      rst     = 1'b1;
      scl     = 1'b1;
      m_low   = 1'b0;
      tx_data = 8'h00;
      wait_clk(3);
      check("rst_rx_data",  32'(rx_data),  32'h00);
      check("rst_rx_valid", 32'(rx_valid), 32'h0);
      check("rst_tx_req",   32'(tx_req),   32'h0);
      check("rst_busy",     32'(busy),     32'h0);
      check("rst_sda",      32'(sda_bus),  32'h1);
      rst = 1'b0;
      wait_clk(4);

      // Table-driven write transfers.
      for (int i = 0; i < 7; i++) begin
         rx0  = rx_pulses;
         low0 = dut_lows;
         start_cond();
         send_byte(vecs[i].addr, a);
         check("addr_ack", 32'(a),    32'(vecs[i].exp_aack));
         check("busy_mid", 32'(busy), 32'(vecs[i].exp_busy));
         send_byte(vecs[i].data, a);
         check("data_ack", 32'(a),    32'(vecs[i].exp_dack));
         wait_clk(2);
         check("rx_valid_cnt", 32'(rx_pulses - rx0), 32'(vecs[i].exp_rx));
         check("rx_data",      32'(rx_data),         32'(vecs[i].exp_rxd));
         stop_cond();
         check("busy_end", 32'(busy), 32'h0);
         if (!vecs[i].exp_aack) check("dut_quiet", 32'(dut_lows - low0), 32'h0);
      end

      // Read with master NACK.
      tx_data = 8'h3C;
      tx0 = tx_pulses;
      start_cond();
      send_byte(8'hA3, a);
      check("rd_addr_ack", 32'(a), 32'h1);
      read8(b);
      check("rd_byte", 32'(b), 32'h3C);
      clk_bit(1'b0, s);
      check("rd_nack_release", 32'(s), 32'h1);
      check("rd_tx_req_cnt", 32'(tx_pulses - tx0), 32'h1);
      check("rd_busy_wait", 32'(busy), 32'h1);
      low0 = dut_lows;
      clk_bit(1'b0, s);
      clk_bit(1'b0, s);
      check("wait_stop_quiet", 32'(dut_lows - low0), 32'h0);
      stop_cond();
      check("rd_busy_end", 32'(busy), 32'h0);

      // Two-byte read: master ACKs the first byte.
      tx_data = 8'h3C;
      tx0 = tx_pulses;
      start_cond();
      send_byte(8'hA3, a);
      check("mrd_addr_ack", 32'(a), 32'h1);
      read8(b);
      check("mrd_byte0", 32'(b), 32'h3C);
      tx_data = 8'hC3;
      clk_bit(1'b1, s);
      read8(b);
      check("mrd_byte1", 32'(b), 32'hC3);
      clk_bit(1'b0, s);
      check("mrd_nack_release", 32'(s), 32'h1);
      check("mrd_tx_req_cnt", 32'(tx_pulses - tx0), 32'h2);
      stop_cond();

      // Repeated START from write into read.
      rx0 = rx_pulses;
      tx_data = 8'h5A;
      start_cond();
      send_byte(8'hA2, a);
      check("rs_addr_ack", 32'(a), 32'h1);
      send_byte(8'h11, a);
      check("rs_data_ack", 32'(a), 32'h1);
      start_cond();
      send_byte(8'hA3, a);
      check("rs_raddr_ack", 32'(a), 32'h1);
      check("rs_rx_data", 32'(rx_data), 32'h11);
      check("rs_rx_cnt", 32'(rx_pulses - rx0), 32'h1);
      check("rs_busy", 32'(busy), 32'h1);
      read8(b);
      check("rs_read_byte", 32'(b), 32'h5A);
      clk_bit(1'b0, s);
      stop_cond();
      check("rs_busy_end", 32'(busy), 32'h0);

      // STOP after 4 data bits: partial byte dropped.
      rx0 = rx_pulses;
      start_cond();
      send_byte(8'hA2, a);
      check("ab_addr_ack", 32'(a), 32'h1);
      clk_bit(1'b0, s);
      clk_bit(1'b1, s);
      clk_bit(1'b0, s);
      clk_bit(1'b1, s);
      stop_cond();
      check("ab_rx_cnt",  32'(rx_pulses - rx0), 32'h0);
      check("ab_rx_data", 32'(rx_data),         32'h11);
      check("ab_busy",    32'(busy),            32'h0);
      check("ab_sda",     32'(sda_bus),         32'h1);

      // Reset pulse while the address ACK is being driven.
      rx0 = rx_pulses;
      start_cond();
      for (int i = 7; i >= 0; i--) begin
         b = 8'hA2;
         clk_bit(~b[i], s);
      end
      wait_clk(4);
      m_low = 1'b0;
      #1;
      check("rs_ack_before_rst", 32'(sda_bus), 32'h0);
      rst = 1'b1;
      #1;
      check("rst_sda_release", 32'(sda_bus), 32'h1);
      check("rst_busy_clear",  32'(busy),    32'h0);
      wait_clk(2);
      rst = 1'b0;
      low0 = dut_lows;
      clk_bit(1'b0, s);
      send_byte(8'h33, a);
      check("post_rst_no_ack", 32'(a), 32'h0);
      check("post_rst_quiet",  32'(dut_lows - low0), 32'h0);
      check("post_rst_rx_cnt", 32'(rx_pulses - rx0), 32'h0);
      check("post_rst_rx_data", 32'(rx_data), 32'h00);
      stop_cond();

      // Normal write after the abort.
      rx0 = rx_pulses;
      start_cond();
      send_byte(8'hA2, a);
      check("rec_addr_ack", 32'(a), 32'h1);
      send_byte(8'h77, a);
      check("rec_data_ack", 32'(a), 32'h1);
      wait_clk(2);
      check("rec_rx_data", 32'(rx_data), 32'h77);
      check("rec_rx_cnt", 32'(rx_pulses - rx0), 32'h1);
      stop_cond();
      check("rec_busy_end", 32'(busy), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
